tc0260dar_palette: RTL and testbench
====================================

Name: tc0260dar_palette

Overview:
- Palette/DAC stage directly downstream of the tilemap generator and its priority mixer.
- Takes the 14-bit colour index stream (SC-style: palette bank + pixel) and looks it up in external 16-bit palette RAM.
- Expands the entry to 8-bit R/G/B and blanks the output outside the active area.
- Arbitrates 68000 CPU access to the same palette RAM on a fixed time-slot basis.

Parameters:
- RGB555, 0, 0: entries are xRGB444 (R=[15:12], G=[11:8], B=[7:4]). 1: entries are xRGB555 (R=[14:10], G=[9:5], B=[4:0]).
- ADDR_W, 13, palette RAM word-address width. Colour index bits above ADDR_W are dropped.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- ce_13m  in  1  13 MHz clock enable
- ce_pixel  in  1  pixel enable; asserts on alternate ce_13m ticks
- VA  in  13 [13:1]  CPU word address
- Din  in  16  CPU write data
- Dout  out  16  CPU read data
- LDSn, UDSn  in  1 each  byte strobes, active-low
- CSn  in  1  chip select, active-low
- RW  in  1  1=read
- DACKn  out  1  DTACK, active-low
- RA  out  ADDR_W  palette RAM address
- RDin  in  16  RAM read data, valid on the ce_13m tick after RA is driven
- RDout  out  16  RAM write data (=Din)
- RWEUPn, RWELOn  out  1 each  byte write enables, active-low, one ce_13m tick wide
- IM  in  14  colour index from mixer
- HBLOn, VBLOn  in  1 each  blank inputs, active-low
- R, G, B  out  8 each  pixel colour
- HBLOn_o, VBLOn_o  out  1 each  blanks delayed to align with RGB

Behaviour:
- Reset values: Dout=0, DACKn=1, RA=0, RWEUPn=RWELOn=1, R=G=B=0, delayed blanks=0, CPU slot FSM in IDLE.
- Slots (ce_13m ticks only):
  - Tick with ce_pixel=1 is the VIDEO slot: RA<=IM[ADDR_W-1:0], blanks sampled into the delay pipe.
  - Next tick (ce_pixel=0) is the CPU slot: RA<=VA if a CPU access is active.
- RDin captured one tick after each slot drive.
- Video latency is fixed at 2 pixel clocks from IM sample to RGB update. Blank outputs use the same 2-deep delay.
- Blanking: when either delayed blank is 0, R=G=B=0 regardless of RAM data.
- Colour expansion:
  - 4-bit x becomes {x,x}.
  - 5-bit x becomes {x,x[4:2]}.
  - So 0 maps to 0x00, and all-ones maps to 0xFF.
- CPU FSM:
  - IDLE: falling edge of CSn (prev_csn=1, CSn=0) goes to PEND.
  - PEND: at the next CPU slot, drive RA=VA. For a write, pulse RWEUPn=UDSn, RWELOn=LDSn. Go to DATA.
  - DATA: on the next ce_13m tick, Dout<=RDin for reads (Dout unchanged for writes). DACKn<=0. Go to ACK.
  - ACK: hold DACKn=0 while CSn=0. When CSn=1, DACKn<=1 and go to IDLE.
- CSn rising while in PEND or DATA aborts: no write pulse if not yet issued, DACKn stays 1, return to IDLE.
- The video slot is never delayed by the CPU. The CPU waits at most 2 ce_13m ticks for its slot.
- The CPU and video paths may address the same entry. A CPU write becomes visible to video from the next video slot onward; no bypass.
- Reset asserted mid-access: FSM to IDLE, DACKn=1, enables deasserted on that clock, partial write is not completed.
- ce_13m low: all state holds.

Decomposition:
- Shared package tc0260dar_pkg:
  - typedef cpu_state_t {IDLE, PEND, DATA, ACK}
  - function expand4(), function expand5()
  - localparam VIDEO_LATENCY=2
- Natural sub-module: tc0260dar_cpu_slot (CPU FSM, strobe/DTACK generation).
- The top level holds the video pipe and colour expansion.

Test Plan:
- RGB555=0, RAM[0x123]=0xF8C0, IM=0x0123, blanks=1 -> two pixel clocks later R=0xFF, G=0x88, B=0xCC.
- RGB555=1, RAM[0x010]=0x7C1F, IM=0x0010 -> R=0xFF, G=0x00, B=0xFF. Same with HBLOn=0 -> RGB=0, HBLOn_o=0 aligned.
- CPU word write VA=0x0005, Din=0x1234, UDSn=LDSn=0 -> exactly one RWEUPn/RWELOn low tick with RA=5. DACKn low within 3 ce_13m ticks and held until CSn rises. A read then returns Dout=0x1234.
- Byte write UDSn=0, LDSn=1, Din=0xAB00 onto 0x1234 -> RAM=0xAB34. Only RWEUPn pulses.
- Continuous IM ramp with back-to-back CPU writes -> RGB stream has no gaps or shifts (2-clock latency preserved every pixel).
- Reset asserted while in PEND -> no write pulse, DACKn=1, FSM IDLE. A new CSn edge after reset completes normally.

Source files
------------

// File: rtl/tc0260dar_pkg.sv
// Shared types and helpers for the TC0260DAR palette/DAC block.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package tc0260dar_pkg;

  // CPU access sequencing through the shared palette RAM port
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    DATA = 2'd2,
    ACK  = 2'd3
  } cpu_state_t;

  // Pixel clocks from the IM sample to the RGB update; the blank pipe has this depth
  localparam int VIDEO_LATENCY = 2;

  // Replicate the nibble so 0x0 -> 0x00 and 0xF -> 0xFF
  function automatic logic [7:0] expand4(input logic [3:0] x);
    return {x, x};
  endfunction

  // Refill the low bits with the top bits so 0x00 -> 0x00 and 0x1F -> 0xFF
  function automatic logic [7:0] expand5(input logic [4:0] x);
    return {x, x[4:2]};
  endfunction

endpackage

// File: rtl/tc0260dar_cpu_slot.sv
// 68000-side access sequencer: CSn edge detect, RAM slot claim, write strobes, DTACK.
// Latency: DACKn low 2-3 ce_13m ticks after the tick that sees the CSn fall.
// Backpressure: CPU is stalled through DTACK; it waits at most 2 ticks for its slot.
module tc0260dar_cpu_slot
  import tc0260dar_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ce_13m,
  input  logic        ce_pixel,
  input  logic        CSn,
  input  logic        RW,
  input  logic        UDSn,
  input  logic        LDSn,
  input  logic [15:0] RDin,
  output logic        cpu_drive,
  output logic [15:0] Dout,
  output logic        DACKn,
  output logic        RWEUPn,
  output logic        RWELOn
);

  cpu_state_t  state_q, state_d;
  logic        prev_csn_q, prev_csn_d;
  logic        rd_q, rd_d;
  logic [15:0] dout_q, dout_d;
  logic        dackn_q, dackn_d;
  logic        rweupn_q, rweupn_d;
  logic        rwelon_q, rwelon_d;

  // Next-state: everything advances only on ce_13m ticks; strobes last exactly one tick
  always_comb begin
    state_d    = state_q;
    prev_csn_d = prev_csn_q;
    rd_d       = rd_q;
    dout_d     = dout_q;
    dackn_d    = dackn_q;
    rweupn_d   = rweupn_q;
    rwelon_d   = rwelon_q;
    cpu_drive  = 1'b0;
    if (ce_13m) begin
      prev_csn_d = CSn;
      rweupn_d   = 1'b1;
      rwelon_d   = 1'b1;
      case (state_q)
        IDLE: begin
          if (prev_csn_q && !CSn) state_d = PEND;
        end
        PEND: begin
          // a deselect before the slot abandons the access with no strobe issued
          if (CSn) begin
            state_d = IDLE;
          end else if (!ce_pixel) begin
            cpu_drive = 1'b1;
            rd_d      = RW;
            if (!RW) begin
              rweupn_d = UDSn;
              rwelon_d = LDSn;
            end
            state_d = DATA;
          end
        end
        DATA: begin
          if (CSn) begin
            state_d = IDLE;
          end else begin
            if (rd_q) dout_d = RDin;
            dackn_d = 1'b0;
            state_d = ACK;
          end
        end
        ACK: begin
          if (CSn) begin
            dackn_d = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State register; a CSn already low when reset releases is not taken as a new access
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      prev_csn_q <= 1'b0;
      rd_q       <= 1'b0;
      dout_q     <= 16'h0000;
      dackn_q    <= 1'b1;
      rweupn_q   <= 1'b1;
      rwelon_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      prev_csn_q <= prev_csn_d;
      rd_q       <= rd_d;
      dout_q     <= dout_d;
      dackn_q    <= dackn_d;
      rweupn_q   <= rweupn_d;
      rwelon_q   <= rwelon_d;
    end
  end

  assign Dout   = dout_q;
  assign DACKn  = dackn_q;
  assign RWEUPn = rweupn_q;
  assign RWELOn = rwelon_q;

endmodule

// File: rtl/tc0260dar_palette.sv
// Palette lookup + RGB expansion + blanking, sharing the palette RAM with the 68000.
// Latency: 2 pixel clocks from IM sample to R/G/B and delayed blanks.
// Backpressure: none on video (fixed slots); CPU is throttled via DACKn.
module tc0260dar_palette
  import tc0260dar_pkg::*;
#(
  parameter bit RGB555 = 1'b0,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce_13m,
  input  logic              ce_pixel,
  input  logic [13:1]       VA,
  input  logic [15:0]       Din,
  output logic [15:0]       Dout,
  input  logic              LDSn,
  input  logic              UDSn,
  input  logic              CSn,
  input  logic              RW,
  output logic              DACKn,
  output logic [ADDR_W-1:0] RA,
  input  logic [15:0]       RDin,
  output logic [15:0]       RDout,
  output logic              RWEUPn,
  output logic              RWELOn,
  input  logic [13:0]       IM,
  input  logic              HBLOn,
  input  logic              VBLOn,
  output logic [7:0]        R,
  output logic [7:0]        G,
  output logic [7:0]        B,
  output logic              HBLOn_o,
  output logic              VBLOn_o
);

  logic                     cpu_drive;
  logic [ADDR_W-1:0]        ra_q, ra_d;
  logic [15:0]              vid_dat_q, vid_dat_d;
  logic [15:0]              pix_q, pix_d;
  logic [VIDEO_LATENCY-1:0] hbl_pipe_q, hbl_pipe_d;
  logic [VIDEO_LATENCY-1:0] vbl_pipe_q, vbl_pipe_d;
  logic [7:0]               r_q, r_d, g_q, g_d, b_q, b_d;
  logic                     hblo_q, hblo_d, vblo_q, vblo_d;
  logic [7:0]               exp_r, exp_g, exp_b;
  logic                     unused_bits;

  tc0260dar_cpu_slot u_cpu_slot (
    .clk      (clk),
    .reset    (reset),
    .ce_13m   (ce_13m),
    .ce_pixel (ce_pixel),
    .CSn      (CSn),
    .RW       (RW),
    .UDSn     (UDSn),
    .LDSn     (LDSn),
    .RDin     (RDin),
    .cpu_drive(cpu_drive),
    .Dout     (Dout),
    .DACKn    (DACKn),
    .RWEUPn   (RWEUPn),
    .RWELOn   (RWELOn)
  );

  // Colour expansion of the staged palette word for the configured entry format
  always_comb begin
    exp_r = 8'h00;
    exp_g = 8'h00;
    exp_b = 8'h00;
    if (RGB555) begin
      exp_r = expand5(pix_q[14:10]);
      exp_g = expand5(pix_q[9:5]);
      exp_b = expand5(pix_q[4:0]);
    end else begin
      exp_r = expand4(pix_q[15:12]);
      exp_g = expand4(pix_q[11:8]);
      exp_b = expand4(pix_q[7:4]);
    end
  end

  // Slot schedule: video tick drives RA from IM and advances the pipe; the CPU tick
  // captures the video word and lets a pending CPU access claim RA
  always_comb begin
    ra_d       = ra_q;
    vid_dat_d  = vid_dat_q;
    pix_d      = pix_q;
    hbl_pipe_d = hbl_pipe_q;
    vbl_pipe_d = vbl_pipe_q;
    r_d        = r_q;
    g_d        = g_q;
    b_d        = b_q;
    hblo_d     = hblo_q;
    vblo_d     = vblo_q;
    if (ce_13m && ce_pixel) begin
      ra_d       = IM[ADDR_W-1:0];
      hbl_pipe_d = {hbl_pipe_q[VIDEO_LATENCY-2:0], HBLOn};
      vbl_pipe_d = {vbl_pipe_q[VIDEO_LATENCY-2:0], VBLOn};
      pix_d      = vid_dat_q;
      hblo_d     = hbl_pipe_q[VIDEO_LATENCY-1];
      vblo_d     = vbl_pipe_q[VIDEO_LATENCY-1];
      if (hblo_d && vblo_d) begin
        r_d = exp_r;
        g_d = exp_g;
        b_d = exp_b;
      end else begin
        r_d = 8'h00;
        g_d = 8'h00;
        b_d = 8'h00;
      end
    end else if (ce_13m) begin
      vid_dat_d = RDin;
      if (cpu_drive) ra_d = VA[ADDR_W:1];
    end
  end

  // Video pipe registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ra_q       <= '0;
      vid_dat_q  <= 16'h0000;
      pix_q      <= 16'h0000;
      hbl_pipe_q <= '0;
      vbl_pipe_q <= '0;
      r_q        <= 8'h00;
      g_q        <= 8'h00;
      b_q        <= 8'h00;
      hblo_q     <= 1'b0;
      vblo_q     <= 1'b0;
    end else begin
      ra_q       <= ra_d;
      vid_dat_q  <= vid_dat_d;
      pix_q      <= pix_d;
      hbl_pipe_q <= hbl_pipe_d;
      vbl_pipe_q <= vbl_pipe_d;
      r_q        <= r_d;
      g_q        <= g_d;
      b_q        <= b_d;
      hblo_q     <= hblo_d;
      vblo_q     <= vblo_d;
    end
  end

  assign RA      = ra_q;
  assign RDout   = Din;
  assign R       = r_q;
  assign G       = g_q;
  assign B       = b_q;
  assign HBLOn_o = hblo_q;
  assign VBLOn_o = vblo_q;

  // Index bits above the RAM and palette bits outside the active format are dropped
  assign unused_bits = ^{IM[13:ADDR_W], pix_q[15], pix_q[3:0]};

endmodule

// File: tb/tb_tc0260dar_palette.sv
// Scoreboard bench for tc0260dar_palette: one xRGB444 and one xRGB555 instance share a RAM model.
// Latency: pixel expectations are due 2 pixel clocks after the IM sample.
// Backpressure: CPU accesses wait on DACKn with bounded tick budgets.
module tb_tc0260dar_palette;

  logic        clk = 1'b0;
  logic        reset, ce_13m, ce_pixel;
  logic [13:1] VA;
  logic [15:0] Din, RDin;
  logic        LDSn, UDSn, CSn, RW, HBLOn, VBLOn;
  logic [13:0] IM;

  logic [15:0] Dout4, RDout4, Dout5, RDout5;
  logic        DACKn4, RWEUPn4, RWELOn4, DACKn5, RWEUPn5, RWELOn5;
  logic [12:0] RA4, RA5;
  logic [7:0]  R4, G4, B4, R5, G5, B5;
  logic        H4, V4, H5, V5;

  logic [15:0] ram [0:8191];
  int          up_cnt = 0, lo_cnt = 0;
  logic [12:0] wa = '0;

  int vecs = 0, errs = 0;
  int vtick = 0;
  int ph = 0;
  bit last_vid = 0, last_tick = 0;

  typedef struct {
    int          due;
    logic [25:0] e4;
    logic [25:0] e5;
  } exp_t;
  exp_t sb [$];

  always #5 clk = ~clk;

  tc0260dar_palette #(.RGB555(1'b0), .ADDR_W(13)) dut4 (
    .clk(clk), .reset(reset), .ce_13m(ce_13m), .ce_pixel(ce_pixel),
    .VA(VA), .Din(Din), .Dout(Dout4), .LDSn(LDSn), .UDSn(UDSn), .CSn(CSn), .RW(RW),
    .DACKn(DACKn4), .RA(RA4), .RDin(RDin), .RDout(RDout4), .RWEUPn(RWEUPn4), .RWELOn(RWELOn4),
    .IM(IM), .HBLOn(HBLOn), .VBLOn(VBLOn), .R(R4), .G(G4), .B(B4), .HBLOn_o(H4), .VBLOn_o(V4)
  );

  tc0260dar_palette #(.RGB555(1'b1), .ADDR_W(13)) dut5 (
    .clk(clk), .reset(reset), .ce_13m(ce_13m), .ce_pixel(ce_pixel),
    .VA(VA), .Din(Din), .Dout(Dout5), .LDSn(LDSn), .UDSn(UDSn), .CSn(CSn), .RW(RW),
    .DACKn(DACKn5), .RA(RA5), .RDin(RDin), .RDout(RDout5), .RWEUPn(RWEUPn5), .RWELOn(RWELOn5),
    .IM(IM), .HBLOn(HBLOn), .VBLOn(VBLOn), .R(R5), .G(G5), .B(B5), .HBLOn_o(H5), .VBLOn_o(V5)
  );

  // Palette RAM model: asynchronous read, byte writes on ce_13m ticks
  assign RDin = ram[RA4];
  always @(posedge clk) begin
    if (ce_13m) begin
      if (!RWEUPn4) begin ram[RA4][15:8] <= RDout4[15:8]; up_cnt <= up_cnt + 1; wa <= RA4; end
      if (!RWELOn4) begin ram[RA4][7:0]  <= RDout4[7:0];  lo_cnt <= lo_cnt + 1; wa <= RA4; end
    end
  end

  // Clock enables: 4-clock cycle of idle, video tick, idle, CPU tick
  initial begin
    ce_13m = 1'b0; ce_pixel = 1'b0;
    forever begin
      @(posedge clk);
      last_tick = ce_13m;
      last_vid  = ce_13m && ce_pixel;
      if (last_vid) vtick++;
      #1;
      ph = (ph + 1) % 4;
      ce_13m   = (ph == 1) || (ph == 3);
      ce_pixel = (ph == 1);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] x4(input logic [3:0] v);
    return 8'(v * 17);
  endfunction
  function automatic logic [7:0] x5(input logic [4:0] v);
    return 8'((v << 3) | (v >> 2));
  endfunction

  // Monitor: compare both instances whenever an expected pixel falls due
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #4;
      if (last_vid && sb.size() > 0 && sb[0].due == vtick) begin
        e = sb.pop_front();
        chk("pix444", {6'd0, R4, G4, B4, H4, V4}, {6'd0, e.e4});
        chk("pix555", {6'd0, R5, G5, B5, H5, V5}, {6'd0, e.e5});
      end
    end
  end

  // Present one pixel on the next video slot and queue its expectation
  task automatic pix(input logic [13:0] im, input logic hb, input logic vb,
                     input logic [23:0] rgb4, input logic [23:0] rgb5);
    exp_t e;
    do begin @(posedge clk); #2; end while (!last_vid);
    IM = im; HBLOn = hb; VBLOn = vb;
    e.due = vtick + 3;
    e.e4  = {(hb && vb) ? rgb4 : 24'h0, hb, vb};
    e.e5  = {(hb && vb) ? rgb5 : 24'h0, hb, vb};
    sb.push_back(e);
  endtask

  task automatic ramp_pix(input int i, input logic hb);
    logic [15:0] w;
    w = ram[13'h100 + 13'(i)];
    pix(14'(14'h100 + i), hb, 1'b1,
        {x4(w[15:12]), x4(w[11:8]), x4(w[7:4])},
        {x5(w[14:10]), x5(w[9:5]), x5(w[4:0])});
  endtask

  // One CPU bus cycle: bounded DTACK wait, hold, strobe/address/data checks, release
  task automatic cpu_acc(input logic rd, input logic [13:1] va, input logic [15:0] din,
                         input logic uds, input logic lds, input logic [15:0] exp_dout,
                         input int exp_up, input int exp_lo);
    int up0, lo0, n;
    bit got;
    up0 = up_cnt; lo0 = lo_cnt;
    @(posedge clk); #2;
    VA = va; Din = din; RW = rd; UDSn = uds; LDSn = lds; CSn = 1'b0;
    n = 0; got = 0;
    while (!got && n < 8) begin
      @(posedge clk); #2;
      if (last_tick) begin n++; got = (DACKn4 == 1'b0); end
    end
    // detecting tick plus at most two more waiting for the slot, then DATA
    chk("dack_lat", {31'd0, got && (n <= 4)}, 32'd1);
    repeat (6) @(posedge clk);
    #2;
    chk("dack_hold", {31'd0, DACKn4}, 32'd0);
    if (rd) chk("dout", {16'd0, Dout4}, {16'd0, exp_dout});
    chk("wr_up_ticks", up_cnt - up0, exp_up);
    chk("wr_lo_ticks", lo_cnt - lo0, exp_lo);
    if (!rd) chk("wr_addr", {19'd0, wa}, {19'd0, va});
    CSn = 1'b1; UDSn = 1'b1; LDSn = 1'b1; RW = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    chk("dack_rel", {31'd0, DACKn4}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: run did not complete, vectors=%0d", vecs);
    $fatal(1);
  end

  initial begin
    int up0, lo0;
    for (int i = 0; i < 8192; i++) ram[i] <= 16'h0000;
    for (int i = 0; i < 32; i++) ram[13'h100 + 13'(i)] <= 16'((i * 16'h0913) ^ 16'h5A3C);
    ram[13'h123] <= 16'hF8C0;
    ram[13'h010] <= 16'h7C1F;
    reset = 1'b1; VA = '0; Din = '0; CSn = 1'b1; RW = 1'b1; UDSn = 1'b1; LDSn = 1'b1;
    IM = '0; HBLOn = 1'b1; VBLOn = 1'b1;
    repeat (4) @(posedge clk);
    #3;
    chk("rst_dout", {16'd0, Dout4}, 32'd0);
    chk("rst_ctl", {29'd0, DACKn4, RWEUPn4, RWELOn4}, 32'd7);
    chk("rst_ra", {19'd0, RA4}, 32'd0);
    chk("rst_rgb444", {6'd0, R4, G4, B4, H4, V4}, 32'd0);
    chk("rst_rgb555", {6'd0, R5, G5, B5, H5, V5}, 32'd0);
    reset = 1'b0;

    // Directed pixels
    pix(14'h0123, 1'b1, 1'b1, 24'hFF88CC, 24'hF73100);
    pix(14'h0010, 1'b1, 1'b1, 24'h77CC11, 24'hFF00FF);
    pix(14'h0010, 1'b0, 1'b1, 24'h77CC11, 24'hFF00FF);
    pix(14'h0010, 1'b1, 1'b0, 24'h77CC11, 24'hFF00FF);
    pix(14'h2123, 1'b1, 1'b1, 24'hFF88CC, 24'hF73100);
    repeat (16) @(posedge clk);

    // CPU word write, read back, byte write, read back
    cpu_acc(1'b0, 13'h0005, 16'h1234, 1'b0, 1'b0, 16'h0000, 1, 1);
    cpu_acc(1'b1, 13'h0005, 16'h0000, 1'b0, 1'b0, 16'h1234, 0, 0);
    cpu_acc(1'b0, 13'h0005, 16'hAB00, 1'b0, 1'b1, 16'h0000, 1, 0);
    chk("ram_byte", {16'd0, ram[5]}, 32'h0000AB34);
    cpu_acc(1'b1, 13'h0005, 16'h0000, 1'b0, 1'b0, 16'hAB34, 0, 0);

    // CPU write then seen by video
    cpu_acc(1'b0, 13'h0030, 16'h0F0F, 1'b0, 1'b0, 16'h0000, 1, 1);
    pix(14'h0030, 1'b1, 1'b1, 24'h00FF00, 24'h18C67B);

    // Continuous ramp with back-to-back CPU writes elsewhere
    fork
      begin
        for (int i = 0; i < 32; i++) ramp_pix(i, (i != 10));
      end
      begin
        for (int k = 0; k < 4; k++)
          cpu_acc(1'b0, 13'(13'h40 + k), 16'(16'h1111 * (k + 1)), 1'b0, 1'b0, 16'h0, 1, 1);
      end
    join
    chk("ram_ramp_wr", {16'd0, ram[13'h43]}, 32'h00004444);
    repeat (16) @(posedge clk);

    // Reset while an access is pending
    do begin @(posedge clk); #2; end while (!(last_tick && !last_vid));
    up0 = up_cnt; lo0 = lo_cnt;
    VA = 13'h0009; Din = 16'hDEAD; RW = 1'b0; UDSn = 1'b0; LDSn = 1'b0; CSn = 1'b0;
    do begin @(posedge clk); #2; end while (!last_vid);
    reset = 1'b1;
    @(posedge clk); #2;
    CSn = 1'b1; UDSn = 1'b1; LDSn = 1'b1; RW = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    chk("rst_pend_dack", {31'd0, DACKn4}, 32'd1);
    reset = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    chk("rst_pend_up", up_cnt - up0, 32'd0);
    chk("rst_pend_lo", lo_cnt - lo0, 32'd0);
    chk("rst_pend_ram", {16'd0, ram[9]}, 32'd0);
    cpu_acc(1'b0, 13'h0009, 16'hBEEF, 1'b0, 1'b0, 16'h0000, 1, 1);
    cpu_acc(1'b1, 13'h0009, 16'h0000, 1'b0, 1'b0, 16'hBEEF, 0, 0);

    repeat (24) @(posedge clk);
    #3;
    chk("sb_drain", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
